// File: rtl/sat_count_pkg.sv
// rtl/sat_count_pkg.sv - state type and saturating next-state function for 2-bit predictor counters
//
// Purpose: shared definitions for 2-bit saturating branch-direction counters.
//   sat_state_t : 2-bit state type with fixed encoding
//   sat_next()  : one saturating step toward the sampled branch direction
// Kept in a package so predictor tables can reuse the same next-state rule.
package sat_count_pkg;

  typedef enum logic [1:0] {
    STRONGLY_NOT_TAKEN = 2'b00,
    WEAKLY_NOT_TAKEN   = 2'b01,
    WEAKLY_TAKEN       = 2'b10,
    STRONGLY_TAKEN     = 2'b11
  } sat_state_t;

  // One step toward the strong state in the direction of 'decision'.
  // 'fallback' is returned for an unrecognised state so the FSM cannot lock
  // up; callers pass their reset state here.
  // An X/Z decision takes the default arm and holds the state. Synthesis
  // sees that arm as unreachable, so it costs nothing in hardware.
  function automatic sat_state_t sat_next(
    input sat_state_t state,
    input logic       decision,
    input sat_state_t fallback = STRONGLY_NOT_TAKEN
  );
    sat_state_t nxt;
    nxt = fallback;
    case (decision)
      1'b1: begin
        case (state)
          STRONGLY_NOT_TAKEN: nxt = WEAKLY_NOT_TAKEN;
          WEAKLY_NOT_TAKEN:   nxt = WEAKLY_TAKEN;
          WEAKLY_TAKEN:       nxt = STRONGLY_TAKEN;
          STRONGLY_TAKEN:     nxt = STRONGLY_TAKEN;
          default:            nxt = fallback;
        endcase
      end
      1'b0: begin
        case (state)
          STRONGLY_TAKEN:     nxt = WEAKLY_TAKEN;
          WEAKLY_TAKEN:       nxt = WEAKLY_NOT_TAKEN;
          WEAKLY_NOT_TAKEN:   nxt = STRONGLY_NOT_TAKEN;
          STRONGLY_NOT_TAKEN: nxt = STRONGLY_NOT_TAKEN;
          default:            nxt = fallback;
        endcase
      end
      default: nxt = state;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sat_count_2b.sv
// rtl/sat_count_2b.sv - 2-bit saturating up/down counter (Moore FSM) for branch prediction
//
// Purpose: one branch-direction predictor entry. Every rising clock it steps
// one state toward the strong state in the direction of the resolved branch.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset (0 = held in reset)
//   decision      in   resolved branch outcome, 1 = taken
//   status        out  [1:0] current state, straight from the state register
//   predict_taken out  status[1]
// Optional (macro SAT_COUNT_MISPRED_EN):
//   mispredict    out  predict_taken ^ decision (combinational)
//   mispred_count out  [7:0] saturating count of mispredicted edges
//
// Parameter:
//   RESET_STATE   state loaded while reset is low (default STRONGLY_NOT_TAKEN)
module sat_count_2b
  import sat_count_pkg::*;
#(
  parameter logic [1:0] RESET_STATE = 2'b00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       decision,
  output logic [1:0] status,
  output logic       predict_taken
`ifdef SAT_COUNT_MISPRED_EN
  ,
  output logic       mispredict,
  output logic [7:0] mispred_count
`endif
);

  localparam sat_state_t RST_STATE = sat_state_t'(RESET_STATE);

  sat_state_t state_q;
  sat_state_t state_d;

  always_comb begin
    state_d = sat_next(state_q, decision, RST_STATE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore outputs: taken directly from the register, no path from decision.
  assign status        = state_q;
  assign predict_taken = state_q[1];

`ifdef SAT_COUNT_MISPRED_EN
  logic [7:0] mispred_cnt_q;
  logic [7:0] mispred_cnt_d;

  assign mispredict = state_q[1] ^ decision;

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (mispredict && (mispred_cnt_q != 8'hFF)) begin
      mispred_cnt_d = mispred_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mispred_cnt_q <= 8'd0;
    end else begin
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispred_count = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_sat_count_2b.sv
// tb/tb_sat_count_2b.sv - scoreboard testbench for sat_count_2b
module tb_sat_count_2b;

  logic       clock;
  logic       reset;
  logic       decision;
  logic [1:0] status;
  logic       predict_taken;
`ifdef SAT_COUNT_MISPRED_EN
  logic       mispredict;
  logic [7:0] mispred_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [1:0] st;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  logic [1:0] model;

  sat_count_2b #(.RESET_STATE(2'b00)) dut (
    .clock         (clock),
    .reset         (reset),
    .decision      (decision),
    .status        (status),
    .predict_taken (predict_taken)
`ifdef SAT_COUNT_MISPRED_EN
    ,
    .mispredict    (mispredict),
    .mispred_count (mispred_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference step written arithmetically rather than as a state table.
  function automatic logic [1:0] ref_next(input logic [1:0] s, input logic d);
    if (d && s != 2'd3) return s + 2'd1;
    if (!d && s != 2'd0) return s - 2'd1;
    return s;
  endfunction

  // Drive one cycle of stimulus 2 units after a rising edge and queue the
  // state expected once the following edge has sampled it.
  task automatic drive(input logic r, input logic d, input logic [1:0] exp_st, input string nm);
    @(posedge clock);
    #2;
    reset    = r;
    decision = d;
    model    = exp_st;
    exp_q.push_back('{st: exp_st, name: nm});
  endtask

  // Monitor: 1 unit after each rising edge, compare whatever is pending.
  always begin
    exp_t e;
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.name, "_status"}, {30'd0, status}, {30'd0, e.st});
      check({e.name, "_predict"}, {31'd0, predict_taken}, {31'd0, e.st[1]});
    end
  end

  initial begin
    logic d;
    int   s;
    reset    = 1'b0;
    decision = 1'b0;
    model    = 2'b00;

    #1;
    check("reset_status", {30'd0, status}, 32'd0);
    check("reset_predict", {31'd0, predict_taken}, 32'd0);

    // Reset held 2 clocks with random decisions.
    drive(1'b0, 1'($urandom), 2'b00, "rst_hold0");
    drive(1'b0, 1'($urandom), 2'b00, "rst_hold1");

    // Saturate up from 00.
    drive(1'b1, 1'b1, 2'b01, "up1");
    drive(1'b1, 1'b1, 2'b10, "up2");
    drive(1'b1, 1'b1, 2'b11, "up3");
    drive(1'b1, 1'b1, 2'b11, "up4");
    drive(1'b1, 1'b1, 2'b11, "up5");

    // Saturate down from 11.
    drive(1'b1, 1'b0, 2'b10, "dn1");
    drive(1'b1, 1'b0, 2'b01, "dn2");
    drive(1'b1, 1'b0, 2'b00, "dn3");
    drive(1'b1, 1'b0, 2'b00, "dn4");
    drive(1'b1, 1'b0, 2'b00, "dn5");

    // Hysteresis from 00, then climb to 11 and try it from the top.
    drive(1'b1, 1'b1, 2'b01, "hyst_lo1");
    drive(1'b1, 1'b0, 2'b00, "hyst_lo0");
    drive(1'b1, 1'b1, 2'b01, "climb1");
    drive(1'b1, 1'b1, 2'b10, "climb2");
    drive(1'b1, 1'b1, 2'b11, "climb3");
    drive(1'b1, 1'b0, 2'b10, "hyst_hi0");
    drive(1'b1, 1'b1, 2'b11, "hyst_hi1");

    // Asynchronous reset between edges drops the state immediately.
    @(posedge clock);
    #4;
    reset = 1'b0;
    #1;
    check("async_rst_status", {30'd0, status}, 32'd0);
    check("async_rst_predict", {31'd0, predict_taken}, 32'd0);
    model = 2'b00;

    // Random run: seed 777, 35 decisions, reset low for the first two.
    s = $urandom(777);
    for (int i = 0; i < 35; i++) begin
      d = 1'($urandom);
      if (i < 2) drive(1'b0, d, 2'b00, $sformatf("rnd%0d", i));
      else       drive(1'b1, d, ref_next(model, d), $sformatf("rnd%0d", i));
    end

`ifdef SAT_COUNT_MISPRED_EN
    begin
      logic [3:0] dec_v;
      logic [3:0] mis_v;
      logic [1:0] st_v [4];
      dec_v = 4'b0111;     // applied LSB first: 1,1,1,0
      mis_v = 4'b1011;     // expected mispredict: 1,1,0,1
      st_v[0] = 2'b01; st_v[1] = 2'b10; st_v[2] = 2'b11; st_v[3] = 2'b10;
      drive(1'b0, 1'b0, 2'b00, "mp_rst");
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, dec_v[i], st_v[i], $sformatf("mp_st%0d", i));
        #1;
        check($sformatf("mp_flag%0d", i), {31'd0, mispredict}, {31'd0, mis_v[i]});
      end
      @(posedge clock);
      #1;
      check("mp_count3", {24'd0, mispred_count}, 32'd3);

      drive(1'b0, 1'b0, 2'b00, "mp_rst2");
      for (int i = 0; i < 300; i++) begin
        d = ~model[1];
        drive(1'b1, d, ref_next(model, d), $sformatf("mp_force%0d", i));
      end
      @(posedge clock);
      #1;
      check("mp_count_sat", {24'd0, mispred_count}, 32'd255);
    end
`endif

    // Let the monitor drain, bounded by a cycle budget.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #3;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sat_count_2b.md
Name: sat_count_2b

Overview:
- 2-bit saturating up/down counter implemented as a 4-state Moore FSM.
- Used as a branch-direction predictor entry.
- Each clock it samples a resolved branch decision (taken / not taken) and moves one step toward the strong state in that direction.
- The current state is exported as the prediction confidence.

Parameters:
- RESET_STATE, 2'b00, state loaded on reset. Legal values 2'b00..2'b11. Default is STRONGLY_NOT_TAKEN.

Ports:
- clock  input  1  rising-edge clock; only clock in the block.
- reset  input  1  asynchronous, active-low reset; 0 = held in reset.
- decision  input  1  resolved branch outcome; 1 = taken, 0 = not taken. Sampled on rising clock.
- status  output  2  current FSM state, driven directly from the state register (no combinational path from decision).
- predict_taken  output  1  equals status[1]; 1 when the state is WEAKLY_TAKEN or STRONGLY_TAKEN.

Behaviour:
- States, encoding fixed:
  - STRONGLY_NOT_TAKEN = 2'b00
  - WEAKLY_NOT_TAKEN = 2'b01
  - WEAKLY_TAKEN = 2'b10
  - STRONGLY_TAKEN = 2'b11
- Reset:
  - reset=0 immediately, with no clock needed, forces state to RESET_STATE, so status=2'b00 by default and predict_taken=0.
  - Holds for as long as reset=0; clock edges are ignored during reset.
- Release: on the first rising clock with reset=1, normal update begins. No extra wait cycles.
- Update at each rising clock with reset=1, latency 1 cycle (status reflects the decision sampled at that edge):
  - decision=1: 00->01, 01->10, 10->11, 11->11 (saturate high).
  - decision=0: 11->10, 10->01, 01->00, 00->00 (saturate low).
- There is no hold/enable input; every clock edge is an update.
- Reset asserted mid-operation: state returns to RESET_STATE asynchronously, regardless of clock phase.
- decision is X/Z at a sampled edge: state is held unchanged. Simulation-only guard; synthesis treats it as don't-care.
- Default branch of the next-state logic returns RESET_STATE, so the FSM cannot lock up.

Optional Feature:
- Macro: SAT_COUNT_MISPRED_EN.
- When defined, two extra outputs are added:
  - mispredict (1 bit): combinational, = predict_taken XOR decision.
  - mispred_count (8 bits): registered; increments by 1 on each rising clock where reset=1 and mispredict=1; saturates at 8'hFF; cleared to 0 by reset.
- When undefined, these ports and logic are absent and the block behaves exactly as above.

Decomposition:
- Package sat_count_pkg holds:
  - a 2-bit state typedef (sat_state_t);
  - the four state constants;
  - a function sat_next(state, decision) returning the saturated next state.
- Single module; no sub-module needed. Next-state logic lives in the package function for reuse by predictor tables.

Test Plan:
- Reset: hold reset=0 for 2 clocks with decision random -> status=00 and predict_taken=0 throughout. Reset asserted between edges -> status drops to 00 immediately.
- Saturate up: from 00, decision=1 for 5 clocks -> status 01,10,11,11,11; predict_taken rises after the 2nd edge.
- Saturate down: from 11, decision=0 for 5 clocks -> status 10,01,00,00,00.
- Hysteresis: from 11, apply 0 then 1 -> 10 then 11; predict_taken stays 1. From 00, apply 1 then 0 -> 01 then 00.
- Random: seed 777, 35 random decisions (one per 10-unit clock cycle), reset low for the first 2 clocks -> status matches a saturating reference model every cycle.
- SAT_COUNT_MISPRED_EN: from 00, apply decisions 1,1,1,0 -> mispredict 1,1,0,1; mispred_count ends at 3. Force 300 mispredicts -> count holds at 255.
